mda_vidout: RTL and testbench
=============================

MDA_VIDOUT -- requirements
Module: mda_vidout

Interface
REQ-001 SHALL: parameter PIPE_DELAY, default 2, clocks of equal delay applied to all video/sync paths (range 1..8).
REQ-002 SHALL: parameter HS_TIMEOUT, default 2047, clocks without an hsync rising edge before sync is declared lost.
REQ-003 SHALL: parameters MIN_LINES / MAX_LINES, defaults 300 / 600, inclusive valid range of hsync edges per frame.
REQ-004 SHALL: clk  in  1  pixel clock, same clock as the MDA core.
REQ-005 SHALL: reset  in  1  synchronous, active-high reset.
REQ-006 SHALL: hsync_in, vsync_in, video_in, intensity_in, display_enable_in  in  1 each  raw MDA core outputs; vsync_in active-high.
REQ-007 SHALL: hsync_out, vsync_out, video_out, intensity_out  out  1 each  conditioned monitor outputs.
REQ-008 SHALL: lines_per_frame  out  10  hsync count of the last complete frame.
REQ-009 SHALL: sync_lost  out  1  high whenever the lock state is not LOCKED.

Function
REQ-010 SHALL: delay all five inputs through a PIPE_DELAY-stage register pipeline, identical for every signal.
REQ-011 SHALL: hsync_out/vsync_out = the delayed syncs, unmodified; never blanked.
REQ-012 SHALL: video_out/intensity_out = delayed values ANDed with delayed display_enable and with ~sync_lost, registered in the last pipeline stage (no extra latency).
REQ-013 SHALL: detect rising edges of the undelayed hsync_in and vsync_in (one-clock strobes, one clock after the input rises).
REQ-014 SHALL: watchdog counter increments every clock, clears to 0 on hsync strobe, saturates at HS_TIMEOUT; reaching HS_TIMEOUT = timeout.
REQ-015 SHALL: line counter increments on hsync strobe, saturates at 1023.
REQ-016 SHALL: on vsync strobe, latch line counter into lines_per_frame and restart counting at 0; if hsync strobe coincides, the latched value excludes it and the counter restarts at 1.
REQ-017 SHALL: frame_ok = MIN_LINES <= latched count <= MAX_LINES, evaluated at each vsync strobe.
REQ-018 SHALL: lock FSM states SEARCH, ACQUIRE, LOCKED.
REQ-019 SHALL: SEARCH -> ACQUIRE on first vsync strobe with watchdog not timed out; that first count is discarded (partial frame).
REQ-020 SHALL: ACQUIRE -> LOCKED on vsync strobe with frame_ok; ACQUIRE -> SEARCH on vsync strobe with ~frame_ok.
REQ-021 SHALL: LOCKED -> SEARCH on vsync strobe with ~frame_ok.
REQ-022 SHALL: any state -> SEARCH on timeout, with priority over vsync-strobe transitions in the same clock.
REQ-023 SHALL: sync_lost registered from next state, i.e. changes in the same clock edge the FSM changes.

Reset
REQ-024 SHALL: reset clears pipeline, counters, lines_per_frame to 0, FSM to SEARCH; all outputs 0 except sync_lost = 1.
REQ-025 SHALL: reset asserted mid-frame discards the partial count; the next vsync strobe is treated as the SEARCH-exit partial frame.

Configuration
REQ-026 SHALL: macro MDA_VIDOUT_LINECOUNT_EN defined: line counting, lines_per_frame and frame_ok as above.
REQ-027 SHALL: macro undefined: no line counter, lines_per_frame tied 0, frame_ok treated as 1 (lock depends only on hsync watchdog and vsync presence).

Structure
REQ-028 SHALL: shared package mda_vidout_pkg holds the FSM state enum and LINE_CNT_W = 10.
REQ-029 SHALL: one sub-module, mda_edge_det (registered rising-edge strobe), instantiated for hsync and vsync.

Verification (params HS_TIMEOUT=63, MIN_LINES=4, MAX_LINES=6, PIPE_DELAY=2)
REQ-030 SHALL: reset, then video_in=1, display_enable_in=1, no syncs -> video_out stays 0, sync_lost=1.
REQ-031 SHALL: hsync every 20 clks, vsync every 5 lines -> sync_lost falls at the 2nd vsync strobe after reset; lines_per_frame=5; video_out follows video_in 2 clks later.
REQ-032 SHALL: locked, then hsync stops -> sync_lost rises 63 clks after the last hsync strobe; video_out forced 0 the same clock.
REQ-033 SHALL: locked, one frame with 8 lines -> lines_per_frame=8, sync_lost=1 from that vsync strobe; two 5-line frames -> relocked.
REQ-034 SHALL: hsync and vsync rise in the same clock -> latched count excludes it, next frame count starts at 1.
REQ-035 SHALL: macro undefined, 20-line frames -> lock after 2 vsync strobes, lines_per_frame=0.

Source files
------------

// File: rtl/mda_vidout_pkg.sv
// Shared types for the MDA video output conditioner: lock FSM states,
// the pipelined video/sync bundle and the line counter width.
package mda_vidout_pkg;

  localparam int unsigned LINE_CNT_W = 10;

  typedef enum logic [1:0] {
    SEARCH,
    ACQUIRE,
    LOCKED
  } lock_state_e;

  typedef struct packed {
    logic hs;
    logic vs;
    logic vid;
    logic inten;
    logic de;
  } vid_bus_t;

endpackage

// File: rtl/mda_edge_det.sv
// Registered rising-edge detector: one-clock strobe, one clock after the
// input rises.
module mda_edge_det
  import mda_vidout_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic strobe_out
);

  logic prev_q, prev_d;
  logic strobe_q, strobe_d;

  always_comb begin
    prev_d   = sig_in;
    strobe_d = sig_in & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      strobe_q <= strobe_d;
    end
  end

  assign strobe_out = strobe_q;

endmodule

// File: rtl/mda_vidout.sv
// MDA monitor output stage: equal-delay pipeline, hsync watchdog, sync lock FSM.
// Line counting / frame-length check is built only with MDA_VIDOUT_LINECOUNT_EN.
module mda_vidout
  import mda_vidout_pkg::*;
#(
  parameter int unsigned PIPE_DELAY = 2,
  parameter int unsigned HS_TIMEOUT = 2047,
  parameter int unsigned MIN_LINES  = 300,
  parameter int unsigned MAX_LINES  = 600
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  video_in,
  input  logic                  intensity_in,
  input  logic                  display_enable_in,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic                  video_out,
  output logic                  intensity_out,
  output logic [LINE_CNT_W-1:0] lines_per_frame,
  output logic                  sync_lost
);

  localparam int unsigned EARLY_N = (PIPE_DELAY > 1) ? PIPE_DELAY - 1 : 1;
  localparam int unsigned WD_W    = $clog2(HS_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(HS_TIMEOUT);

  vid_bus_t    raw, tap;
  vid_bus_t    early_q [EARLY_N];
  vid_bus_t    early_d [EARLY_N];
  logic        hs_out_q, vs_out_q, vid_out_q, int_out_q;
  logic        hs_out_d, vs_out_d, vid_out_d, int_out_d;
  logic        hs_stb, vs_stb;
  logic [WD_W-1:0] wd_q, wd_d;
  logic        timeout;
  logic        frame_ok;
  lock_state_e state_q, state_d;
  logic        sync_lost_q, sync_lost_d;

  mda_edge_det u_hs_edge (.clk(clk), .reset(reset), .sig_in(hsync_in), .strobe_out(hs_stb));
  mda_edge_det u_vs_edge (.clk(clk), .reset(reset), .sig_in(vsync_in), .strobe_out(vs_stb));

  // The last stage is the blanking register, so gating adds no latency and
  // uses the next lock state to blank on the same edge sync_lost rises.
  always_comb begin
    raw.hs    = hsync_in;
    raw.vs    = vsync_in;
    raw.vid   = video_in;
    raw.inten = intensity_in;
    raw.de    = display_enable_in;
    early_d[0] = raw;
    for (int unsigned i = 1; i < EARLY_N; i++) early_d[i] = early_q[i-1];
    tap = (PIPE_DELAY > 1) ? early_q[EARLY_N-1] : raw;
    hs_out_d  = tap.hs;
    vs_out_d  = tap.vs;
    vid_out_d = tap.vid   & tap.de & ~sync_lost_d;
    int_out_d = tap.inten & tap.de & ~sync_lost_d;
  end

  always_comb begin
    if (hs_stb)            wd_d = '0;
    else if (wd_q == WD_MAX) wd_d = wd_q;
    else                   wd_d = wd_q + WD_W'(1);
    timeout = (wd_d == WD_MAX);
  end

`ifdef MDA_VIDOUT_LINECOUNT_EN
  logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d, lpf_q, lpf_d;

  // A coincident hsync strobe belongs to the new frame, not the latched one.
  always_comb begin
    line_cnt_d = line_cnt_q;
    lpf_d      = lpf_q;
    if (vs_stb) begin
      lpf_d      = line_cnt_q;
      line_cnt_d = hs_stb ? LINE_CNT_W'(1) : '0;
    end else if (hs_stb && line_cnt_q != '1) begin
      line_cnt_d = line_cnt_q + LINE_CNT_W'(1);
    end
    frame_ok = (32'(line_cnt_q) >= MIN_LINES) && (32'(line_cnt_q) <= MAX_LINES);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      line_cnt_q <= '0;
      lpf_q      <= '0;
    end else begin
      line_cnt_q <= line_cnt_d;
      lpf_q      <= lpf_d;
    end
  end

  assign lines_per_frame = lpf_q;
`else
  assign frame_ok        = 1'b1;
  assign lines_per_frame = '0;
`endif

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = SEARCH;
    end else if (vs_stb) begin
      case (state_q)
        SEARCH:  state_d = ACQUIRE;
        ACQUIRE: state_d = frame_ok ? LOCKED : SEARCH;
        LOCKED:  state_d = frame_ok ? LOCKED : SEARCH;
        default: state_d = SEARCH;
      endcase
    end
    sync_lost_d = (state_d != LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < EARLY_N; i++) early_q[i] <= '0;
      hs_out_q    <= 1'b0;
      vs_out_q    <= 1'b0;
      vid_out_q   <= 1'b0;
      int_out_q   <= 1'b0;
      wd_q        <= '0;
      state_q     <= SEARCH;
      sync_lost_q <= 1'b1;
    end else begin
      for (int unsigned i = 0; i < EARLY_N; i++) early_q[i] <= early_d[i];
      hs_out_q    <= hs_out_d;
      vs_out_q    <= vs_out_d;
      vid_out_q   <= vid_out_d;
      int_out_q   <= int_out_d;
      wd_q        <= wd_d;
      state_q     <= state_d;
      sync_lost_q <= sync_lost_d;
    end
  end

  assign hsync_out     = hs_out_q;
  assign vsync_out     = vs_out_q;
  assign video_out     = vid_out_q;
  assign intensity_out = int_out_q;
  assign sync_lost     = sync_lost_q;

endmodule

// File: tb/tb_mda_vidout.sv
// Directed bench for mda_vidout (HS_TIMEOUT=63, MIN/MAX_LINES=4/6, PIPE_DELAY=2);
// expectations follow MDA_VIDOUT_LINECOUNT_EN when it is defined.
module tb_mda_vidout;

`ifdef MDA_VIDOUT_LINECOUNT_EN
  localparam bit LC_EN = 1'b1;
`else
  localparam bit LC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       hsync_in, vsync_in, video_in, intensity_in, display_enable_in;
  logic       hsync_out, vsync_out, video_out, intensity_out, sync_lost;
  logic [9:0] lines_per_frame;

  int n_cmp = 0;
  int n_bad = 0;

  logic [19:0] vid_pat, int_pat, de_pat;
  logic [19:0] vo_cap, io_cap, hso_cap, vso_cap;
  logic        sl_pre, sl_post;
  logic [9:0]  lpf_post;
  int          ones;

  always #5 clk = ~clk;

  mda_vidout #(
    .PIPE_DELAY(2),
    .HS_TIMEOUT(63),
    .MIN_LINES (4),
    .MAX_LINES (6)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .hsync_in         (hsync_in),
    .vsync_in         (vsync_in),
    .video_in         (video_in),
    .intensity_in     (intensity_in),
    .display_enable_in(display_enable_in),
    .hsync_out        (hsync_out),
    .vsync_out        (vsync_out),
    .video_out        (video_out),
    .intensity_out    (intensity_out),
    .lines_per_frame  (lines_per_frame),
    .sync_lost        (sync_lost)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk10(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One frame of 20-clock lines; hsync high c=0..3, vsync high in line 0 from
  // c=vs_off for 3 clocks. Line 0 outputs and the vsync-strobe response are captured.
  task automatic frame(input int lines, input int vs_off);
    for (int l = 0; l < lines; l++) begin
      for (int c = 0; c < 20; c++) begin
        hsync_in          = (c < 4);
        vsync_in          = (l == 0) && (c >= vs_off) && (c < vs_off + 3);
        video_in          = vid_pat[c];
        intensity_in      = int_pat[c];
        display_enable_in = de_pat[c];
        step();
        if (l == 0) begin
          vo_cap[c]  = video_out;
          io_cap[c]  = intensity_out;
          hso_cap[c] = hsync_out;
          vso_cap[c] = vsync_out;
          if (c == vs_off) sl_pre = sync_lost;
          if (c == vs_off + 1) begin
            sl_post  = sync_lost;
            lpf_post = lines_per_frame;
          end
        end
      end
    end
  endtask

  initial begin
    vid_pat = 20'hA5C3F;
    int_pat = 20'h3C9A6;
    de_pat  = 20'hFFF0F;
    reset = 1'b1;
    hsync_in = 1'b0; vsync_in = 1'b0; video_in = 1'b0;
    intensity_in = 1'b0; display_enable_in = 1'b0;
    repeat (3) step();
    chk1 ("rst_sync_lost", sync_lost, 1'b1);
    chk1 ("rst_video", video_out, 1'b0);
    chk1 ("rst_hsync", hsync_out, 1'b0);
    chk10("rst_lpf", lines_per_frame, 10'd0);

    // no syncs: video stays blanked
    reset = 1'b0;
    video_in = 1'b1; intensity_in = 1'b1; display_enable_in = 1'b1;
    ones = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      ones += int'(video_out | intensity_out);
    end
    chk10("nosync_video_ones", 10'(ones), 10'd0);
    chk1 ("nosync_sync_lost", sync_lost, 1'b1);

    // lock on 5-line frames
    frame(5, 10);
    chk1 ("A_sl_post", sl_post, 1'b1);
    chk10("A_lpf", lpf_post, LC_EN ? 10'd1 : 10'd0);
    frame(5, 10);
    chk1 ("B_sl_pre", sl_pre, 1'b1);
    chk1 ("B_sl_post", sl_post, 1'b0);
    chk10("B_lpf", lpf_post, LC_EN ? 10'd5 : 10'd0);
    frame(5, 10);
    chk1 ("C_sl_post", sl_post, 1'b0);
    chk10("C_lpf", lpf_post, LC_EN ? 10'd5 : 10'd0);
    for (int c = 1; c < 20; c++) begin
      chk1($sformatf("C_video_c%0d", c), vo_cap[c], vid_pat[c-1] & de_pat[c-1]);
      chk1($sformatf("C_inten_c%0d", c), io_cap[c], int_pat[c-1] & de_pat[c-1]);
      chk1($sformatf("C_hsync_c%0d", c), hso_cap[c], (c - 1) < 4);
      chk1($sformatf("C_vsync_c%0d", c), vso_cap[c], (c - 1 >= 10) && (c - 1 < 13));
    end

    // hsync stops: one last pulse, then timeout after 63 more clocks
    hsync_in = 1'b1; vsync_in = 1'b0;
    video_in = 1'b1; intensity_in = 1'b1; display_enable_in = 1'b1;
    step();
    hsync_in = 1'b0;
    repeat (63) step();
    chk1("to_sl_before", sync_lost, 1'b0);
    chk1("to_video_before", video_out, 1'b1);
    step();
    chk1("to_sl_at", sync_lost, 1'b1);
    chk1("to_video_at", video_out, 1'b0);
    chk1("to_inten_at", intensity_out, 1'b0);

    // relock, then an 8-line frame
    frame(5, 10);
    chk1 ("F1_sl_post", sl_post, 1'b1);
    frame(5, 10);
    chk1 ("F2_sl_post", sl_post, 1'b0);
    frame(8, 10);
    chk1 ("F3_sl_post", sl_post, 1'b0);
    frame(5, 10);
    chk1 ("F4_sl_pre", sl_pre, 1'b0);
    chk1 ("F4_sl_post", sl_post, LC_EN);
    chk10("F4_lpf", lpf_post, LC_EN ? 10'd8 : 10'd0);
    frame(5, 10);
    chk1 ("F5_sl_post", sl_post, LC_EN);
    frame(5, 10);
    chk1 ("F6_sl_post", sl_post, 1'b0);

    // hsync and vsync rising together
    frame(5, 10);
    chk10("F7_lpf", lpf_post, LC_EN ? 10'd5 : 10'd0);
    frame(5, 0);
    chk10("F8_lpf_coinc", lpf_post, LC_EN ? 10'd4 : 10'd0);
    chk1 ("F8_sl_post", sl_post, 1'b0);
    frame(5, 10);
    chk10("F9_lpf_after", lpf_post, LC_EN ? 10'd6 : 10'd0);
    chk1 ("F9_sl_post", sl_post, 1'b0);

    // reset mid-frame, then 20-line frames
    frame(3, 10);
    reset = 1'b1;
    repeat (2) step();
    chk1 ("mid_rst_sl", sync_lost, 1'b1);
    chk10("mid_rst_lpf", lines_per_frame, 10'd0);
    reset = 1'b0;
    frame(20, 10);
    chk1 ("G1_sl_post", sl_post, 1'b1);
    chk10("G1_lpf", lpf_post, LC_EN ? 10'd1 : 10'd0);
    frame(20, 10);
    chk1 ("G2_sl_post", sl_post, LC_EN);
    chk10("G2_lpf", lpf_post, LC_EN ? 10'd20 : 10'd0);
    frame(20, 10);
    chk1 ("G3_sl_post", sl_post, LC_EN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
